// File: rtl/event_counter.sv
// Debounced sensor event counter, 0..9999, with alarm and sticky overflow.
// A 2-flop synchronizer feeds a 4-state debounce FSM whose rise pulse drives the count.
module event_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ALARM_LEVEL     = 9000,
  parameter int WRAP            = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sensor_in,
  input  logic        enable,
  input  logic        clr,
  output logic [13:0] count,
  output logic        count_evt,
  output logic        alarm,
  output logic        overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [13:0] MAXC = 14'd9999;
  localparam logic [13:0] ALARM_C = 14'(ALARM_LEVEL);

  typedef enum logic [1:0] {
    STABLE_LO,
    CHECK_HI,
    STABLE_HI,
    CHECK_LO
  } state_t;

  logic          s1;
  logic          s2;
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] dcnt;
  logic [CW-1:0] dcnt_nxt;
  logic          rise;
  logic          rise_nxt;

  logic [13:0]   count_nxt;
  logic          evt_nxt;
  logic          ovf_nxt;
  logic          alarm_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sensor_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE_LO;
      dcnt  <= '0;
      rise  <= 1'b0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
      rise  <= rise_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    unique case (state)
      STABLE_LO: begin
        if (s2) begin
          state_nxt = CHECK_HI;
          dcnt_nxt  = ONE;
        end
      end
      CHECK_HI: begin
        if (!s2) begin
          state_nxt = STABLE_LO;
        end else if (dcnt == CMAX) begin
          state_nxt = STABLE_HI;
        end else begin
          dcnt_nxt = dcnt + ONE;
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          state_nxt = CHECK_LO;
          dcnt_nxt  = ONE;
        end
      end
      CHECK_LO: begin
        if (s2) begin
          state_nxt = STABLE_HI;
        end else if (dcnt == CMAX) begin
          state_nxt = STABLE_LO;
        end else begin
          dcnt_nxt = dcnt + ONE;
        end
      end
      default: state_nxt = STABLE_LO;
    endcase
  end

  // Registered so the count lands DEBOUNCE_CYCLES+3 edges after the input.
  always_comb begin
    rise_nxt = (state == CHECK_HI) && s2 && (dcnt == CMAX);
  end

  always_comb begin
    count_nxt = count;
    evt_nxt   = 1'b0;
    ovf_nxt   = overflow;
    if (clr) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (rise && enable) begin
      if (count == MAXC) begin
        ovf_nxt = 1'b1;
        if (WRAP != 0) begin
          count_nxt = '0;
          evt_nxt   = 1'b1;
        end
      end else begin
        count_nxt = count + 14'd1;
        evt_nxt   = 1'b1;
      end
    end
    alarm_nxt = (count_nxt >= ALARM_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      count_evt <= 1'b0;
      alarm     <= (ALARM_LEVEL == 0);
      overflow  <= 1'b0;
    end else begin
      count     <= count_nxt;
      count_evt <= evt_nxt;
      alarm     <= alarm_nxt;
      overflow  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_event_counter.sv
// Scoreboard bench for event_counter: main instance plus wrap and
// saturate instances with a short debounce.
module tb_event_counter;

  typedef struct packed {
    logic [13:0] c;
    logic        a;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sensor;
  logic sensor_w;
  logic enable;
  logic clr;

  logic [13:0] count, count_w, count_s;
  logic evt, evt_w, evt_s;
  logic alarm, alarm_w, alarm_s;
  logic ovf, ovf_w, ovf_s;

  exp_t q[$];
  exp_t qw[$];

  int total = 0;
  int bad = 0;
  int s_evts = 0;

  event_counter #(
    .DEBOUNCE_CYCLES(4),
    .ALARM_LEVEL(3),
    .WRAP(1)
  ) dut (
    .clk(clk), .rst(rst), .sensor_in(sensor),
    .enable(enable), .clr(clr), .count(count),
    .count_evt(evt), .alarm(alarm), .overflow(ovf)
  );

  event_counter #(
    .DEBOUNCE_CYCLES(2),
    .ALARM_LEVEL(9000),
    .WRAP(1)
  ) dut_w (
    .clk(clk), .rst(rst), .sensor_in(sensor_w),
    .enable(1'b1), .clr(1'b0), .count(count_w),
    .count_evt(evt_w), .alarm(alarm_w), .overflow(ovf_w)
  );

  event_counter #(
    .DEBOUNCE_CYCLES(2),
    .ALARM_LEVEL(9000),
    .WRAP(0)
  ) dut_s (
    .clk(clk), .rst(rst), .sensor_in(sensor_w),
    .enable(1'b1), .clr(1'b0), .count(count_s),
    .count_evt(evt_s), .alarm(alarm_s), .overflow(ovf_s)
  );

  function automatic void chk(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(int h, int l);
    sensor = 1'b1;
    tick(h);
    sensor = 1'b0;
    tick(l);
  endtask

  task automatic pulse_w();
    sensor_w = 1'b1;
    tick(3);
    sensor_w = 1'b0;
    tick(3);
  endtask

  // Monitors: every count_evt must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (evt) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL main_unexpected_evt: count=%0d", count);
      end else begin
        e = q.pop_front();
        chk("main_evt", int'({count, alarm, ovf}), int'(e));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (evt_w) begin
      if (qw.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wrap_unexpected_evt: count=%0d", count_w);
      end else begin
        e = qw.pop_front();
        chk("wrap_evt", int'({count_w, alarm_w, ovf_w}), int'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (evt_s) s_evts++;
  end

  initial begin
    int hw[10] = '{1, 2, 3, 1, 3, 2, 1, 2, 3, 3};
    int cyc;
    int k;
    rst = 1'b1;
    sensor = 1'b0;
    sensor_w = 1'b0;
    enable = 1'b1;
    clr = 1'b0;
    tick(3);
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_evt", evt, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_ovf", ovf, 0);

    // Bounce: no run of high samples reaches 4
    cyc = 0;
    for (int i = 0; cyc < 40; i++) begin
      pulse(hw[i % 10], 1 + (i % 2));
      cyc += hw[i % 10] + 1 + (i % 2);
    end
    tick(12);
    chk("bounce_count", count, 0);

    // Clean step, event at edge 7
    q.push_back('{c: 14'd1, a: 1'b0, o: 1'b0});
    sensor = 1'b1;
    tick(6);
    chk("step_edge6", count, 0);
    tick(1);
    chk("step_edge7", count, 1);
    chk("step_evt", evt, 1);
    tick(1);
    chk("step_evt_1cyc", evt, 0);
    sensor = 1'b0;
    tick(10);
    chk("fall_count", count, 1);

    // Alarm and enable
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_count", count, 0);
    q.push_back('{c: 14'd1, a: 1'b0, o: 1'b0});
    q.push_back('{c: 14'd2, a: 1'b0, o: 1'b0});
    q.push_back('{c: 14'd3, a: 1'b1, o: 1'b0});
    repeat (3) pulse(8, 8);
    chk("alarm_count", count, 3);
    chk("alarm_on", alarm, 1);
    enable = 1'b0;
    repeat (2) pulse(8, 8);
    chk("disabled_count", count, 3);
    enable = 1'b1;

    // clr collides with an accepted rise
    sensor = 1'b1;
    tick(6);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("coll_count", count, 0);
    chk("coll_ovf", ovf, 0);
    chk("coll_evt", evt, 0);
    chk("coll_alarm", alarm, 0);
    tick(2);
    sensor = 1'b0;
    tick(8);
    q.push_back('{c: 14'd1, a: 1'b0, o: 1'b0});
    pulse(8, 8);
    chk("after_coll", count, 1);

    // Reset during CHECK_HI with sensor held high
    sensor = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_count", count, 0);
    chk("midrst_evt", evt, 0);
    chk("midrst_alarm", alarm, 0);
    chk("midrst_ovf", ovf, 0);
    q.push_back('{c: 14'd1, a: 1'b0, o: 1'b0});
    tick(6);
    chk("midrst_edge6", count, 0);
    tick(1);
    chk("midrst_edge7", count, 1);
    sensor = 1'b0;
    tick(12);
    chk("midrst_once", count, 1);

    // Preload to 9999, then one more event
    for (int i = 1; i <= 9999; i++) begin
      qw.push_back('{c: 14'(i), a: (i >= 9000), o: 1'b0});
      pulse_w();
    end
    chk("pre_wrap", count_w, 9999);
    chk("pre_sat", count_s, 9999);
    qw.push_back('{c: 14'd0, a: 1'b0, o: 1'b1});
    pulse_w();
    tick(6);
    chk("wrap_count", count_w, 0);
    chk("wrap_ovf", ovf_w, 1);
    chk("sat_count", count_s, 9999);
    chk("sat_ovf", ovf_s, 1);
    chk("sat_alarm", alarm_s, 1);
    chk("sat_evts", s_evts, 9999);

    k = 0;
    while ((q.size() + qw.size()) != 0 && k < 50) begin
      tick(1);
      k++;
    end
    chk("queues_drained", q.size() + qw.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
